// File: rtl/mealey_decim_avg_if.sv
// Sample/result stream bundle between the Mealy stage, the block averager and its consumer.
interface mealey_decim_avg_if #(
    parameter int unsigned DATA_W = 9
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     clr;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               blk_cnt;

    modport master (
        output in_data, in_valid, clr, out_ready,
        input  in_ready, out_data, out_valid, blk_cnt
    );

    modport slave (
        input  in_data, in_valid, clr, out_ready,
        output in_ready, out_data, out_valid, blk_cnt
    );
endinterface

// File: rtl/mealey_decim_avg.sv
// Block averager: sums 2**DECIM_LOG2 signed samples, floors the mean and queues it
// in a 2-entry FIFO so a slow consumer back-pressures the sample stream.
module mealey_decim_avg #(
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned DATA_W     = 9
) (
    input  logic               system1000,
    input  logic               system1000_rstn,
    mealey_decim_avg_if.slave  bus
);
    localparam int unsigned           ACC_W    = DATA_W + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t              state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DECIM_LOG2-1:0]    cnt_q, cnt_d;
    logic signed [DATA_W-1:0] head_q, head_d;
    logic signed [DATA_W-1:0] tail_q, tail_d;
    logic [7:0]               blk_cnt_q, blk_cnt_d;

    logic signed [ACC_W-1:0]  in_sext;
    logic signed [ACC_W-1:0]  blk_sum;
    logic signed [DATA_W-1:0] avg;
    logic                     in_ready;
    logic                     out_valid;
    logic                     accept;
    logic                     last;
    logic                     push;
    logic                     pop;

    // Ready only depends on registered state, so it never waits on out_ready.
    assign in_ready  = (cnt_q != CNT_LAST) || (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign last      = (cnt_q == CNT_LAST);
    assign push      = accept & ~bus.clr & last;
    assign pop       = out_valid & bus.out_ready;

    assign in_sext = ACC_W'($signed(bus.in_data));
    assign blk_sum = acc_q + in_sext;
    assign avg     = DATA_W'(blk_sum >>> DECIM_LOG2);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_q;
    assign bus.blk_cnt   = blk_cnt_q;

    // Accumulator and block position; clr restarts the block, optionally seeded by the sample.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        blk_cnt_d = blk_cnt_q;
        if (bus.clr) begin
            acc_d = accept ? in_sext : '0;
            cnt_d = accept ? DECIM_LOG2'(1) : '0;
        end else if (accept) begin
            if (last) begin
                acc_d     = '0;
                cnt_d     = '0;
                blk_cnt_d = blk_cnt_q + 8'd1;
            end else begin
                acc_d = blk_sum;
                cnt_d = cnt_q + DECIM_LOG2'(1);
            end
        end
    end

    // Output FIFO occupancy; head_q is always the presented result.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = avg;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b11: head_d = avg;
                    2'b10: begin
                        tail_d  = avg;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end
endmodule

// File: tb/tb_mealey_decim_avg.sv
// Scoreboard bench for mealey_decim_avg: directed scenarios plus a randomized stream.
module tb_mealey_decim_avg;
    localparam int unsigned DECIM_LOG2 = 2;
    localparam int unsigned DATA_W     = 9;
    localparam int          N          = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mealey_decim_avg_if #(.DATA_W(DATA_W)) bus ();

    mealey_decim_avg #(
        .DECIM_LOG2 (DECIM_LOG2),
        .DATA_W     (DATA_W)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int blk_sum_m = 0;
    int blk_len_m = 0;
    int blk_exp   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int floor_div(input int s);
        int r;
        r = s % N;
        if (r < 0) r += N;
        return (s - r) / N;
    endfunction

    // Reference: a block is N accepted samples; its result is the floored mean.
    task automatic model_accept(input int v, input bit c);
        if (c) begin
            blk_sum_m = v;
            blk_len_m = 1;
        end else begin
            blk_sum_m += v;
            blk_len_m++;
            if (blk_len_m == N) begin
                exp_q.push_back(floor_div(blk_sum_m));
                blk_sum_m = 0;
                blk_len_m = 0;
                blk_exp++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one sample; returns at posedge+1 after it is taken (or after a timeout).
    task automatic send(input int v, input bit c, input bit kick);
        int waited;
        waited       = 0;
        bus.in_data  = DATA_W'(v);
        bus.in_valid = 1'b1;
        bus.clr      = c;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            waited++;
            if (kick && waited > 2) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("in_ready timeout", 0, 1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_accept(v, c);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
    endtask

    // Monitor: every handshake on the output side pops one expected result.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstn && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("result with empty scoreboard", int'(bus.out_data), 99999);
                else check("result", int'(bus.out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;
        rstn          = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset in_ready", int'(bus.in_ready), 1);
        #20 rstn = 1'b1;
        idle(1);
        check("reset blk_cnt", int'(bus.blk_cnt), 0);
        check("reset out_data", int'(bus.out_data), 0);

        // T1 basic average and latency
        bus.out_ready = 1'b1;
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
        check("t1 out_valid after 4th accept", int'(bus.out_valid), 1);
        check("t1 out_data", int'(bus.out_data), 2);
        check("t1 blk_cnt", int'(bus.blk_cnt), 1);
        idle(2);

        // T2 sign handling and extremes
        send(-1, 0, 0); send(-2, 0, 0); send(-2, 0, 0); send(-2, 0, 0);
        repeat (4) send(255, 0, 0);
        repeat (4) send(-256, 0, 0);
        send(255, 0, 0); send(-256, 0, 0); send(255, 0, 0); send(-256, 0, 0);
        idle(3);
        check("t2 blk_cnt", int'(bus.blk_cnt), blk_exp % 256);

        // T3 backpressure: FIFO fills, 12th sample held until the first pop
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 11; k++) send(4 * k, 0, 0);
        check("t3 in_ready held", int'(bus.in_ready), 0);
        check("t3 out_valid", int'(bus.out_valid), 1);
        check("t3 head", int'(bus.out_data), 10);
        check("t3 blk_cnt", int'(bus.blk_cnt), blk_exp % 256);
        bus.in_data   = DATA_W'(48);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3 in_ready before pop", int'(bus.in_ready), 0);
        @(negedge clk);
        check("t3 in_ready after pop", int'(bus.in_ready), 1);
        @(posedge clk);
        model_accept(48, 0);
        #1 bus.in_valid = 1'b0;
        idle(5);

        // T4 push and pop in the same cycle keep occupancy at ONE
        bus.out_ready = 1'b0;
        repeat (4) send(1, 0, 0);
        repeat (3) send(8, 0, 0);
        bus.out_ready = 1'b1;
        send(8, 0, 0);
        check("t4 out_valid", int'(bus.out_valid), 1);
        check("t4 head", int'(bus.out_data), 8);
        idle(1);
        check("t4 drained after one pop", int'(bus.out_valid), 0);

        // T5 clr alone, then clr together with a sample at the last block position
        send(7, 0, 0); send(7, 0, 0);
        bus.clr = 1'b1;
        @(posedge clk);
        blk_sum_m = 0;
        blk_len_m = 0;
        #1 bus.clr = 1'b0;
        repeat (4) send(1, 0, 0);
        idle(2);
        repeat (3) send(7, 0, 0);
        send(5, 1, 0);
        idle(2);
        check("t5 no push on clr", int'(bus.out_valid), 0);
        check("t5 blk_cnt", int'(bus.blk_cnt), blk_exp % 256);
        repeat (3) send(5, 0, 0);
        idle(3);

        // T6 asynchronous reset with a full FIFO and a partial block
        bus.out_ready = 1'b0;
        repeat (10) send(3, 0, 0);
        check("t6 fifo full", int'(bus.out_valid), 1);
        #2 rstn = 1'b0;
        #1;
        check("t6 out_valid in reset", int'(bus.out_valid), 0);
        exp_q.delete();
        blk_sum_m = 0;
        blk_len_m = 0;
        blk_exp   = 0;
        @(negedge clk);
        check("t6 in_ready in reset", int'(bus.in_ready), 1);
        #2 rstn = 1'b1;
        idle(1);
        check("t6 blk_cnt after reset", int'(bus.blk_cnt), 0);
        check("t6 out_data after reset", int'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
        idle(3);
        check("t6 blk_cnt", int'(bus.blk_cnt), 1);

        // Randomized stream with random consumer stalls and occasional clr
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) idle(1);
            send(int'($urandom_range(0, 511)) - 256, ($urandom_range(0, 15) == 0), 1'b1);
        end
        bus.out_ready = 1'b1;
        idle(6);
        check("random drain", exp_q.size(), 0);
        check("random blk_cnt", int'(bus.blk_cnt), blk_exp % 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
